// File: rtl/bank_arb_pkg.sv
// Shared defaults and bank-number helpers for the bank/bank-group arbiter.
// Bank j lives in group j/NBA at position j%NBA.
package bank_arb_pkg;

    localparam int NBG_D       = 4;
    localparam int NBA_D       = 4;
    localparam int CCD_L_D     = 4;
    localparam int CCD_S_D     = 2;
    localparam int BURST_MAX_D = 4;

    function automatic int bank_bg(input int j, input int nba);
        return j / nba;
    endfunction

    function automatic int bank_ba(input int j, input int nba);
        return j % nba;
    endfunction

endpackage

// File: rtl/bank_group_arbiter_rr_picker.sv
// Round-robin first-set finder: lowest set bit of req at or after ptr,
// wrapping modulo W (W is a power of two).
module rr_picker #(
    parameter  int W  = 4,
    localparam int PW = $clog2(W)
) (
    input  logic [W-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          en,
    output logic          found,
    output logic [PW-1:0] idx
);

    // Scan from the far end so the closest offset to ptr wins last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (en && req[ptr + PW'(i)]) begin
                found = 1'b1;
                idx   = ptr + PW'(i);
            end
        end
    end

endmodule

// File: rtl/bank_group_arbiter.sv
// Two-level bank/bank-group arbiter with CCD_L/CCD_S spacing, group
// interleave, burst cap and a registered valid/ready command slot.
module bank_group_arbiter
    import bank_arb_pkg::*;
#(
    parameter int IDX       = 6,
    parameter int RA        = 16,
    parameter int CA        = 10,
    parameter int DQ        = 16,
    parameter int NBG       = NBG_D,
    parameter int NBA       = NBA_D,
    parameter int BURST_MAX = BURST_MAX_D,
    parameter int CCD_L     = CCD_L_D,
    parameter int CCD_S     = CCD_S_D,
    localparam int N        = NBG * NBA,
    localparam int BGW      = $clog2(NBG),
    localparam int BAW      = $clog2(NBA)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    valid,
    input  logic [N*DQ-1:0] data_i,
    input  logic [N*IDX-1:0] idx_i,
    input  logic [N*RA-1:0] row_i,
    input  logic [N*CA-1:0] col_i,
    input  logic [N-1:0]    t_i,
    output logic [N-1:0]    ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DQ-1:0]   data_o,
    output logic [IDX-1:0]  idx_o,
    output logic [RA-1:0]   row_o,
    output logic [CA-1:0]   col_o,
    output logic            t_o,
    output logic [BGW-1:0]  bg_o,
    output logic [BAW-1:0]  ba_o
);

    localparam int NW  = BGW + BAW;
    localparam int SLW = $clog2(CCD_L + 1);
    localparam int SAW = $clog2(CCD_S + 1);
    localparam int BCW = $clog2(BURST_MAX + 1);

    logic [NBG-1:0] grp_valid;
    logic [NBG-1:0] elig;
    logic [NBG-1:0] bfound;
    logic [BAW-1:0] bidx     [NBG];
    logic [BAW-1:0] ptr      [NBG];
    logic [SLW-1:0] since_bg [NBG];
    logic [SAW-1:0] since_any;
    logic [BGW-1:0] cur_bg;
    logic [BGW-1:0] rr_ptr;
    logic [BGW-1:0] rr_idx;
    logic [BGW-1:0] gsel;
    logic [BCW-1:0] burst_cnt;
    logic [BAW-1:0] bsel;
    logic [NW-1:0]  bank;
    logic           rr_found;
    logic           pick_cur;
    logic           other_valid;
    logic           slot_free;
    logic           grant;

    for (genvar g = 0; g < NBG; g++) begin : g_grp
        assign grp_valid[g] = |valid[g*NBA +: NBA];
        assign elig[g] = grp_valid[g]
                      && (since_bg[g] >= SLW'(CCD_L))
                      && (since_any >= SAW'(CCD_S));

        rr_picker #(.W(NBA)) u_bank (
            .req   (valid[g*NBA +: NBA]),
            .ptr   (ptr[g]),
            .en    (1'b1),
            .found (bfound[g]),
            .idx   (bidx[g])
        );
    end

    assign slot_free   = !out_valid || out_ready;
    assign other_valid = |(grp_valid & ~(NBG'(1) << cur_bg));
    assign pick_cur    = elig[cur_bg]
                      && ((burst_cnt < BCW'(BURST_MAX)) || !other_valid);
    assign rr_ptr      = cur_bg + BGW'(1);

    rr_picker #(.W(NBG)) u_grp (
        .req   (elig),
        .ptr   (rr_ptr),
        .en    (slot_free),
        .found (rr_found),
        .idx   (rr_idx)
    );

    // Held low through reset so no queue pops while the state is clearing.
    assign grant = rst_n && slot_free && (pick_cur || rr_found);
    assign gsel  = pick_cur ? cur_bg : rr_idx;
    assign bsel  = bidx[gsel];
    assign bank  = {gsel, bsel};
    assign ready = grant ? (N'(1) << bank) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            data_o    <= '0;
            idx_o     <= '0;
            row_o     <= '0;
            col_o     <= '0;
            t_o       <= 1'b0;
            bg_o      <= '0;
            ba_o      <= '0;
        end else if (grant) begin
            out_valid <= 1'b1;
            data_o    <= data_i[int'(bank)*DQ +: DQ];
            idx_o     <= idx_i[int'(bank)*IDX +: IDX];
            row_o     <= row_i[int'(bank)*RA +: RA];
            col_o     <= col_i[int'(bank)*CA +: CA];
            t_o       <= t_i[bank];
            bg_o      <= BGW'(bank_bg(int'(bank), NBA));
            ba_o      <= BAW'(bank_ba(int'(bank), NBA));
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            since_any <= SAW'(CCD_S);
            cur_bg    <= BGW'(NBG - 1);
            burst_cnt <= BCW'(BURST_MAX);
            for (int g = 0; g < NBG; g++) begin
                since_bg[g] <= SLW'(CCD_L);
                ptr[g]      <= '0;
            end
        end else begin
            if (grant) begin
                since_any <= SAW'(1);
            end else if (since_any < SAW'(CCD_S)) begin
                since_any <= since_any + SAW'(1);
            end
            for (int g = 0; g < NBG; g++) begin
                if (grant && (gsel == BGW'(g))) begin
                    since_bg[g] <= SLW'(1);
                    ptr[g]      <= bsel + BAW'(1);
                end else if (since_bg[g] < SLW'(CCD_L)) begin
                    since_bg[g] <= since_bg[g] + SLW'(1);
                end
            end
            if (grant) begin
                if (gsel == cur_bg) begin
                    if (burst_cnt < BCW'(BURST_MAX)) begin
                        burst_cnt <= burst_cnt + BCW'(1);
                    end
                end else begin
                    cur_bg    <= gsel;
                    burst_cnt <= BCW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_bank_group_arbiter.sv
// Directed bench: main instance at defaults plus a CCD_L=CCD_S=1 instance
// for the burst-cap rotation; granted banks are queued and checked on output.
module tb_bank_group_arbiter;
    import bank_arb_pkg::*;

    localparam int IDX = 6;
    localparam int RA  = 16;
    localparam int CA  = 10;
    localparam int DQ  = 16;
    localparam int NBG = 4;
    localparam int NBA = 4;
    localparam int N   = NBG * NBA;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    valid;
    logic [N*DQ-1:0] data_i;
    logic [N*IDX-1:0] idx_i;
    logic [N*RA-1:0] row_i;
    logic [N*CA-1:0] col_i;
    logic [N-1:0]    t_i;
    logic            out_ready;

    logic [N-1:0]    ready;
    logic            out_valid;
    logic [DQ-1:0]   data_o;
    logic [IDX-1:0]  idx_o;
    logic [RA-1:0]   row_o;
    logic [CA-1:0]   col_o;
    logic            t_o;
    logic [1:0]      bg_o;
    logic [1:0]      ba_o;

    logic [N-1:0]    ready_b;
    logic            out_valid_b;
    logic [DQ-1:0]   data_o_b;
    logic [IDX-1:0]  idx_o_b;
    logic [RA-1:0]   row_o_b;
    logic [CA-1:0]   col_o_b;
    logic            t_o_b;
    logic [1:0]      bg_o_b;
    logic [1:0]      ba_o_b;

    int total = 0;
    int bad   = 0;
    int q[$];
    logic exp_ov;

    bank_group_arbiter dut (
        .clk(clk), .rst_n(rst_n), .valid(valid), .data_i(data_i),
        .idx_i(idx_i), .row_i(row_i), .col_i(col_i), .t_i(t_i),
        .ready(ready), .out_valid(out_valid), .out_ready(out_ready),
        .data_o(data_o), .idx_o(idx_o), .row_o(row_o), .col_o(col_o),
        .t_o(t_o), .bg_o(bg_o), .ba_o(ba_o)
    );

    bank_group_arbiter #(.CCD_L(1), .CCD_S(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .valid(valid), .data_i(data_i),
        .idx_i(idx_i), .row_i(row_i), .col_i(col_i), .t_i(t_i),
        .ready(ready_b), .out_valid(out_valid_b), .out_ready(out_ready),
        .data_o(data_o_b), .idx_o(idx_o_b), .row_o(row_o_b),
        .col_o(col_o_b), .t_o(t_o_b), .bg_o(bg_o_b), .ba_o(ba_o_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] onehot(input int b);
        logic [63:0] v;
        v = '0;
        if (b >= 0) v[b] = 1'b1;
        return v;
    endfunction

    task automatic chk_fields(input int b);
        chk("data_o", 64'(data_o), 64'(data_i[b*DQ +: DQ]));
        chk("idx_o", 64'(idx_o), 64'(idx_i[b*IDX +: IDX]));
        chk("row_o", 64'(row_o), 64'(row_i[b*RA +: RA]));
        chk("col_o", 64'(col_o), 64'(col_i[b*CA +: CA]));
        chk("t_o", 64'(t_o), 64'(t_i[b]));
        chk("bg_o", 64'(bg_o), 64'(bank_bg(b, NBA)));
        chk("ba_o", 64'(ba_o), 64'(bank_ba(b, NBA)));
    endtask

    // One cycle on the main instance; eb is the expected granted bank or -1.
    task automatic cyc(input int eb);
        @(negedge clk);
        chk("ready", 64'(ready), onehot(eb));
        chk("out_valid", 64'(out_valid), 64'(exp_ov));
        if (exp_ov) begin
            if (q.size() == 0) chk("sb_empty", 64'(1), 64'(0));
            else chk_fields(q[0]);
        end
        @(posedge clk);
        if (exp_ov && out_ready && q.size() > 0) void'(q.pop_front());
        exp_ov = (eb >= 0) || (exp_ov && !out_ready);
        if (eb >= 0) q.push_back(eb);
        #1;
    endtask

    task automatic cyc_b(input int eb);
        @(negedge clk);
        chk("ready_b", 64'(ready_b), onehot(eb));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        valid     = '0;
        out_ready = 1'b1;
        q.delete();
        exp_ov    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        valid     = '1;
        out_ready = 1'b1;
        exp_ov    = 1'b0;
        for (int j = 0; j < N; j++) begin
            data_i[j*DQ +: DQ]   = 16'(16'hA000 + j * 37);
            idx_i[j*IDX +: IDX]  = 6'(j + 3);
            row_i[j*RA +: RA]    = 16'(256 + j * 3);
            col_i[j*CA +: CA]    = 10'(j * 5 + 1);
            t_i[j]               = (j % 2) == 1;
        end

        // reset state, requests present but held in reset
        @(negedge clk);
        chk("rst_ready", 64'(ready), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_data_o", 64'(data_o), 64'(0));
        chk("rst_bg_o", 64'(bg_o), 64'(0));
        chk("rst_ba_o", 64'(ba_o), 64'(0));

        // single request, bank 5
        do_reset();
        valid = N'(1) << 5;
        cyc(5);
        valid = '0;
        cyc(-1);
        cyc(-1);

        // same-group spacing
        do_reset();
        valid = N'(16'h000F);
        for (int c = 0; c < 17; c++)
            cyc((c % 4 == 0) ? (c / 4) % 4 : -1);

        // group interleave
        do_reset();
        valid = N'(16'h0011);
        for (int c = 0; c < 8; c++)
            cyc((c % 2 == 1) ? -1 : ((c % 4 == 0) ? 0 : 4));

        // burst cap on the tight-spacing instance
        do_reset();
        valid = '1;
        for (int c = 0; c < 17; c++)
            cyc_b(c % 16);

        // backpressure
        do_reset();
        valid     = N'(16'h0001);
        valid[1]  = 1'b1;
        out_ready = 1'b0;
        cyc(0);
        for (int c = 0; c < 5; c++) cyc(-1);
        out_ready = 1'b1;
        cyc(1);
        cyc(-1);

        // reset mid-operation
        do_reset();
        valid = N'(16'h000F);
        cyc(0);
        cyc(-1);
        cyc(-1);
        cyc(-1);
        cyc(1);
        rst_n = 1'b0;
        #1;
        chk("mid_out_valid", 64'(out_valid), 64'(0));
        chk("mid_data_o", 64'(data_o), 64'(0));
        chk("mid_ba_o", 64'(ba_o), 64'(0));
        chk("mid_ready", 64'(ready), 64'(0));
        q.delete();
        exp_ov = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(0);
        cyc(-1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
